axi_write_burst_ctrl: RTL

AXI_WRITE_BURST_CTRL -- requirements
Module: axi_write_burst_ctrl

---
 rtl/axi_write_burst_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_write_burst_ctrl.sv
// AXI4 write-burst slave front end: accepts AW/W beats, drives a single-port
// memory write interface under arbiter grant, and queues B responses in a FIFO.
module axi_write_burst_ctrl #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_WDATA_WIDTH   = 64,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI4_USER_WIDTH    = 10,
  parameter int unsigned AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
  parameter int unsigned MEM_ADDR_WIDTH     = 16,
  parameter int unsigned B_FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
  input  logic [7:0]                    AWLEN_i,
  input  logic [2:0]                    AWSIZE_i,
  input  logic [1:0]                    AWBURST_i,
  input  logic                          AWLOCK_i,
  input  logic [3:0]                    AWCACHE_i,
  input  logic [2:0]                    AWPROT_i,
  input  logic [3:0]                    AWREGION_i,
  input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
  input  logic [3:0]                    AWQOS_i,
  input  logic                          AWVALID_i,
  output logic                          AWREADY_o,

  input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
  input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
  input  logic                          WLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]    WUSER_i,
  input  logic                          WVALID_i,
  output logic                          WREADY_o,

  output logic [AXI4_ID_WIDTH-1:0]      BID_o,
  output logic [1:0]                    BRESP_o,
  output logic                          BVALID_o,
  output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
  input  logic                          BREADY_i,

  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,

  input  logic                          grant_i,
  output logic                          valid_o
);

  localparam int unsigned OFFS = $clog2(AXI_NUMBYTES);
  localparam int unsigned PW   = $clog2(B_FIFO_DEPTH);

  typedef enum logic {IDLE, DATA} state_t;

  state_t                      state_q, state_d;
  logic [AXI4_ID_WIDTH-1:0]    id_q;
  logic [AXI4_USER_WIDTH-1:0]  user_q;
  logic [7:0]                  len_q, cnt_q;
  logic [1:0]                  burst_q;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_nxt, mask_q;
  logic                        err_q;

  logic                        aw_hs, beat, last_beat, beat_err, aw_bad, wrap_legal;
  logic                        push, pop, full, empty;
  logic [1:0]                  resp_push;

  logic [AXI4_ID_WIDTH-1:0]    fifo_id   [B_FIFO_DEPTH];
  logic [AXI4_USER_WIDTH-1:0]  fifo_user [B_FIFO_DEPTH];
  logic [1:0]                  fifo_resp [B_FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [PW:0]                 fifo_cnt;

  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE_i, AWLOCK_i, AWCACHE_i, AWPROT_i,
                           AWREGION_i, AWQOS_i, WUSER_i};

  // Unsupported WRAP lengths and the reserved burst code fall back to INCR.
  assign wrap_legal = (AWLEN_i == 8'd1) || (AWLEN_i == 8'd3) ||
                      (AWLEN_i == 8'd7) || (AWLEN_i == 8'd15);
  assign aw_bad     = (AWBURST_i == 2'b11) || ((AWBURST_i == 2'b10) && !wrap_legal);

  assign last_beat  = (cnt_q == len_q);
  assign beat_err   = (WLAST_i != last_beat);
  assign resp_push  = (err_q || beat_err) ? 2'b10 : 2'b00;

  assign full  = (fifo_cnt == (PW+1)'(B_FIFO_DEPTH));
  assign empty = (fifo_cnt == '0);

  always_comb begin
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~mask_q) |
                          ((addr_q + MEM_ADDR_WIDTH'(1)) & mask_q);
      default: addr_nxt = addr_q + MEM_ADDR_WIDTH'(1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    AWREADY_o = 1'b0;
    WREADY_o  = 1'b0;
    valid_o   = 1'b0;
    MEM_CEN_o = 1'b1;
    MEM_WEN_o = 1'b1;
    MEM_A_o   = '0;
    MEM_D_o   = '0;
    MEM_BE_o  = '0;
    aw_hs     = 1'b0;
    beat      = 1'b0;
    push      = 1'b0;
    if (rst) begin
      AWREADY_o = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          AWREADY_o = !full;
          aw_hs     = AWVALID_i && !full;
          if (aw_hs) state_d = DATA;
        end
        DATA: begin
          valid_o  = WVALID_i;
          WREADY_o = grant_i;
          beat     = WVALID_i && grant_i;
          if (beat) begin
            MEM_CEN_o = 1'b0;
            MEM_WEN_o = 1'b0;
            MEM_A_o   = addr_q;
            MEM_D_o   = WDATA_i;
            MEM_BE_o  = WSTRB_i;
            if (last_beat) begin
              push    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      user_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q    <= AWID_i;
        user_q  <= AWUSER_i;
        len_q   <= AWLEN_i;
        burst_q <= aw_bad ? 2'b01 : AWBURST_i;
        mask_q  <= MEM_ADDR_WIDTH'(AWLEN_i[3:0]);
        addr_q  <= MEM_ADDR_WIDTH'(AWADDR_i >> OFFS);
        cnt_q   <= '0;
        err_q   <= aw_bad;
      end else if (beat) begin
        addr_q  <= addr_nxt;
        cnt_q   <= cnt_q + 8'd1;
        err_q   <= err_q || beat_err;
      end
    end
  end

  assign pop      = BVALID_o && BREADY_i;
  assign BVALID_o = !empty && !rst;
  assign BID_o    = BVALID_o ? fifo_id[rd_ptr]   : '0;
  assign BUSER_o  = BVALID_o ? fifo_user[rd_ptr] : '0;
  assign BRESP_o  = BVALID_o ? fifo_resp[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]   <= id_q;
      fifo_user[wr_ptr] <= user_q;
      fifo_resp[wr_ptr] <= resp_push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
